mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port round-robin arbiter that shares one `bram_controller` memory port between two requesters, typically the CPU (port 0) and a loader/DMA engine (port 1). Each side uses the same valid/ready/addr/wdata/wstrb/rdata handshake as `bram_controller`. The arbiter registers the winning request and drives the shared port, then returns the response to the owner only. A watchdog aborts any transaction the slave never completes.

## Interface
- `TIMEOUT`, 255: max cycles to wait for `s_ready` after `s_valid` rises. 0 disables the watchdog.
- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-high reset.
- `m0_valid`, `m1_valid` in 1: request from master 0 / 1.
- `m0_addr`, `m1_addr` in 32: byte address.
- `m0_wdata`, `m1_wdata` in 32: write data.
- `m0_wstrb`, `m1_wstrb` in 4: byte enables. 0000 means read.
- `m0_ready`, `m1_ready` out 1: one-cycle completion pulse to that master.
- `m0_rdata`, `m1_rdata` out 32: response data. Valid while the matching ready is 1, and held until that master's next completion.
- `s_valid` out 1: request to `bram_controller` (`mem_valid`).
- `s_addr` out 32, `s_wdata` out 32, `s_wstrb` out 4: registered request fields.
- `s_ready` in 1: slave completion (`mem_ready`).
- `s_rdata` in 32: slave data (`mem_rdata`).
- `timeout_err` out 1: one-cycle pulse when a transaction is aborted.

## Operation
- Registers:
  - `state` ∈ {IDLE, BUSY, RESP}.
  - `owner` (1 bit).
  - `last_grant` (1 bit): reset value 1, so master 0 wins the first tie.
  - `wd_cnt` (8 bit minimum; must hold `TIMEOUT`).
- IDLE:
  - If exactly one `mN_valid` is 1, grant it.
  - If both are 1, grant the master that is not `last_grant`.
  - On grant, at the sampling edge:
    - latch `owner`;
    - copy that master's addr/wdata/wstrb into `s_addr`/`s_wdata`/`s_wstrb`;
    - set `s_valid`=1 and `wd_cnt`=0;
    - go to BUSY.
- BUSY:
  - `s_valid` stays 1 and the `s_*` fields are stable.
  - On an edge with `s_ready`=1:
    - `s_valid`→0;
    - `m<owner>_rdata` ← `s_rdata`;
    - `m<owner>_ready`→1;
    - `last_grant` ← `owner`;
    - go to RESP.
  - Otherwise `wd_cnt` increments. If `TIMEOUT`≠0 and `wd_cnt`==`TIMEOUT`-1:
    - `s_valid`→0;
    - `m<owner>_rdata` ← 32'hDEADBEEF;
    - `m<owner>_ready`→1 and `timeout_err`→1;
    - `last_grant` ← `owner`;
    - go to RESP.
  - Changes on master inputs during BUSY are ignored.
- RESP: the ready/err pulse is visible for exactly this cycle. Next edge: pulses clear and state returns to IDLE. Any new grant is decided there, not in RESP.
- The non-owner's ready stays 0 and its rdata is untouched.
- Masters must hold valid and request fields until they see ready, and must drop valid at the edge after ready. A valid still high in RESP is not re-granted.
- Reset (any time, including mid-BUSY):
  - all outputs 0;
  - state IDLE, `last_grant`=1, `wd_cnt`=0;
  - the in-flight slave transaction is abandoned.

## Timing
- Request sampled at edge E0 → `s_valid`=1 after E0.
- Slave asserts `s_ready` L cycles later, sampled at edge E0+L → `mN_ready`=1 for the cycle after E0+L.
- Total latency from the sampling edge to the ready pulse is L+1 cycles. Earliest next grant is at the edge ending RESP+1.
- Back-to-back requests from both masters alternate 0,1,0,1… while both stay valid.
- `s_*` outputs are registered only; there is no combinational path from `mN_*` to `s_*`.

## Test plan
- **Single read, port 0:** slave preloaded with 0x10→0x0004; `m0` reads 0x10.
  - `s_addr`=0x10, `s_wstrb`=0000.
  - `m0_ready` pulses once with `m0_rdata`=0x00000004.
  - `m1_ready` stays 0.
- **Write then read, port 1:** `m1` writes 0x20←0x0000FF00 (wstrb 1111), then reads 0x20.
  - Write: `m1_ready` pulse.
  - Read: `m1_rdata`=0x0000FF00.
- **Simultaneous requests:** both masters valid after reset, m0 reads 0x10, m1 reads 0x20.
  - m0 is served first, then m1.
  - A second simultaneous pair grants m1 first only if m0 was last. Check with 3 rounds: order 0,1,0,1,0,1.
- **Watchdog:** `TIMEOUT`=8, slave `s_ready` tied 0, m0 reads.
  - After 8 BUSY cycles, `timeout_err` and `m0_ready` pulse together, `m0_rdata`=0xDEADBEEF, `s_valid`=0.
  - The next m1 request is then served normally.
- **Reset mid-transaction:** assert `reset` while BUSY.
  - All outputs are 0 immediately (asynchronous).
  - After release, an m0 and m1 tie grants m0.
- **Hold stability:** change `m0_addr` during BUSY → `s_addr` is unchanged until completion.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter in front of one bram_controller port.
// The winning request is registered onto the shared s_* port. The response goes
// back only to the master that owns the transaction. A watchdog aborts a
// transaction that the slave never completes.
module mem_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic        timeout_err
);

    // The counter is at least 8 bits wide and grows if TIMEOUT needs more.
    localparam int WD_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
    // Count value on the last BUSY edge before the transaction is aborted.
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [31:0] ABORT_DATA = 32'hDEADBEEF;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t          state;
    logic            owner;
    logic            last_grant;
    logic [WD_W-1:0] wd_cnt;
    logic            pick;

    // Winner for a grant in IDLE: the lone requester, or on a tie the master that was not served last.
    always_comb begin
        pick = m1_valid;
        if (m0_valid && m1_valid) begin
            pick = ~last_grant;
        end
    end

    // Arbitration FSM. It drives all registered outputs, including the shared port and the response pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            owner       <= 1'b0;
            last_grant  <= 1'b1;
            wd_cnt      <= '0;
            s_valid     <= 1'b0;
            s_addr      <= '0;
            s_wdata     <= '0;
            s_wstrb     <= '0;
            m0_ready    <= 1'b0;
            m1_ready    <= 1'b0;
            m0_rdata    <= '0;
            m1_rdata    <= '0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        owner   <= pick;
                        s_addr  <= pick ? m1_addr  : m0_addr;
                        s_wdata <= pick ? m1_wdata : m0_wdata;
                        s_wstrb <= pick ? m1_wstrb : m0_wstrb;
                        s_valid <= 1'b1;
                        wd_cnt  <= '0;
                        state   <= BUSY;
                    end
                end

                BUSY: begin
                    if (s_ready) begin
                        s_valid    <= 1'b0;
                        last_grant <= owner;
                        state      <= RESP;
                        if (owner) begin
                            m1_rdata <= s_rdata;
                            m1_ready <= 1'b1;
                        end else begin
                            m0_rdata <= s_rdata;
                            m0_ready <= 1'b1;
                        end
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                        if ((TIMEOUT != 0) && (wd_cnt == WD_LAST)) begin
                            s_valid     <= 1'b0;
                            timeout_err <= 1'b1;
                            last_grant  <= owner;
                            state       <= RESP;
                            if (owner) begin
                                m1_rdata <= ABORT_DATA;
                                m1_ready <= 1'b1;
                            end else begin
                                m0_rdata <= ABORT_DATA;
                                m0_ready <= 1'b1;
                            end
                        end
                    end
                end

                RESP: begin
                    m0_ready    <= 1'b0;
                    m1_ready    <= 1'b0;
                    timeout_err <= 1'b0;
                    state       <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. It contains a bench slave memory, a transaction-level
// reference model that is checked on every clock, and directed tests with
// hand-computed literal expectations.
module tb_mem_arbiter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_valid, m1_valid;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic [3:0]  m0_wstrb, m1_wstrb;
    logic        m0_ready, m1_ready;
    logic [31:0] m0_rdata, m1_rdata;
    logic        s_valid;
    logic [31:0] s_addr, s_wdata;
    logic [3:0]  s_wstrb;
    logic        s_ready = 1'b0;
    logic [31:0] s_rdata = 32'h0;
    logic        timeout_err;

    int vectors = 0;
    int miscompares = 0;

    mem_arbiter #(.TIMEOUT(TMO)) dut (
        .clk(clk), .reset(reset),
        .m0_valid(m0_valid), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_ready(m0_ready), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
        .m1_ready(m1_ready), .m1_rdata(m1_rdata),
        .s_valid(s_valid), .s_addr(s_addr), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
        .s_ready(s_ready), .s_rdata(s_rdata),
        .timeout_err(timeout_err)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // One comparison: count it, and report it if it does not match.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Bench slave. It answers lat cycles after it sees s_valid, or never when slave_en is 0.
    logic [31:0] slv_mem [0:255];
    bit          slave_en;
    int          lat;
    int          wait_cnt = 0;
    always begin
        @(posedge clk);
        #1;
        if (reset) begin
            s_ready  = 1'b0;
            wait_cnt = 0;
        end else if (s_ready) begin
            s_ready = 1'b0;
        end else if (s_valid && slave_en) begin
            if (wait_cnt >= lat - 1) begin
                s_rdata = slv_mem[s_addr[9:2]];
                for (int b = 0; b < 4; b++)
                    if (s_wstrb[b]) slv_mem[s_addr[9:2]][8*b +: 8] = s_wdata[8*b +: 8];
                s_ready  = 1'b1;
                wait_cnt = 0;
            end else begin
                wait_cnt++;
            end
        end else begin
            wait_cnt = 0;
        end
    end

    // Reference model state. It tracks transactions, not the arbiter's registers.
    logic [31:0] ref_mem [0:255];
    bit          m_busy, m_resp, m_owner, m_last;
    int          m_cnt;
    logic [31:0] g_addr, g_wdata, held0, held1;
    logic [3:0]  g_wstrb;
    bit          e_r0, e_r1, e_err;
    int          grant_log[$];
    // Master and slave inputs as they were before the edge that just passed.
    bit          p_mv0, p_mv1, p_sr;
    logic [31:0] p_a0, p_d0, p_a1, p_d1;
    logic [3:0]  p_s0, p_s1;

    // Close the model's transaction: give the response to the owner and record who was served last.
    task automatic finishTxn(input bit aborted);
        logic [31:0] val;
        val = aborted ? 32'hDEADBEEF : ref_mem[g_addr[9:2]];
        if (!aborted)
            for (int b = 0; b < 4; b++)
                if (g_wstrb[b]) ref_mem[g_addr[9:2]][8*b +: 8] = g_wdata[8*b +: 8];
        if (m_owner) begin held1 = val; e_r1 = 1'b1; end
        else         begin held0 = val; e_r0 = 1'b1; end
        e_err  = aborted;
        m_last = m_owner;
        m_busy = 1'b0;
    endtask

    // On every falling edge, advance the model by the edge that just passed and compare the outputs.
    always @(negedge clk) begin
        if (reset) begin
            m_busy = 1'b0; m_resp = 1'b0; m_last = 1'b1; m_cnt = 0;
            held0 = '0; held1 = '0;
        end else begin
            e_r0 = 1'b0; e_r1 = 1'b0; e_err = 1'b0;
            if (m_busy) begin
                if (p_sr) begin
                    finishTxn(1'b0);
                end else begin
                    m_cnt++;
                    if (m_cnt == TMO) finishTxn(1'b1);
                end
            end else if (!m_resp && (p_mv0 || p_mv1)) begin
                m_owner = (p_mv0 && p_mv1) ? !m_last : p_mv1;
                g_addr  = m_owner ? p_a1 : p_a0;
                g_wdata = m_owner ? p_d1 : p_d0;
                g_wstrb = m_owner ? p_s1 : p_s0;
                m_busy  = 1'b1;
                m_cnt   = 0;
                grant_log.push_back(int'(m_owner));
            end
            m_resp = e_r0 | e_r1;
            checkOutput("m0_ready", {31'b0, m0_ready}, {31'b0, e_r0});
            checkOutput("m1_ready", {31'b0, m1_ready}, {31'b0, e_r1});
            checkOutput("timeout_err", {31'b0, timeout_err}, {31'b0, e_err});
            checkOutput("s_valid", {31'b0, s_valid}, {31'b0, m_busy});
            checkOutput("m0_rdata", m0_rdata, held0);
            checkOutput("m1_rdata", m1_rdata, held1);
            if (m_busy) begin
                checkOutput("s_addr", s_addr, g_addr);
                checkOutput("s_wdata", s_wdata, g_wdata);
                checkOutput("s_wstrb", {28'b0, s_wstrb}, {28'b0, g_wstrb});
            end
        end
        p_mv0 = m0_valid; p_a0 = m0_addr; p_d0 = m0_wdata; p_s0 = m0_wstrb;
        p_mv1 = m1_valid; p_a1 = m1_addr; p_d1 = m1_wdata; p_s1 = m1_wstrb;
        p_sr  = s_ready;
    end

    // Issue one request from a master, called just after a rising edge.
    // It waits for ready within a bounded time and drops valid at the edge after ready.
    task automatic applyStimulus(input int port, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [3:0] wstrb, output logic [31:0] rd, output bit err,
                                 output int cyc);
        bit seen;
        seen = 1'b0;
        rd = '0; err = 1'b0; cyc = 0;
        if (port == 0) begin m0_valid = 1'b1; m0_addr = addr; m0_wdata = wdata; m0_wstrb = wstrb; end
        else           begin m1_valid = 1'b1; m1_addr = addr; m1_wdata = wdata; m1_wstrb = wstrb; end
        while (!seen && cyc < 60) begin
            @(posedge clk);
            #1;
            cyc++;
            if (port == 0 && m0_ready) begin seen = 1'b1; rd = m0_rdata; err = timeout_err; end
            if (port == 1 && m1_ready) begin seen = 1'b1; rd = m1_rdata; err = timeout_err; end
        end
        if (!seen) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL ready_wait: port %0d got no ready within %0d cycles, expected one", port, cyc);
        end else begin
            @(posedge clk);
            #1;
        end
        if (port == 0) m0_valid = 1'b0; else m1_valid = 1'b0;
    endtask

    // Pulse reset for a couple of cycles with the masters idle.
    task automatic doReset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    // Both masters request at once; each gets its own expected read data back.
    task automatic tiePair();
        fork
            begin
                logic [31:0] ra; bit ea; int ca;
                applyStimulus(0, 32'h10, 32'h0, 4'h0, ra, ea, ca);
                checkOutput("tie_m0_rdata", ra, 32'h00000004);
            end
            begin
                logic [31:0] rb; bit eb; int cb;
                applyStimulus(1, 32'h20, 32'h0, 4'h0, rb, eb, cb);
                checkOutput("tie_m1_rdata", rb, 32'h0000FF00);
            end
        join
    endtask

    // Compare the grant order recorded by the model against a literal pattern.
    task automatic checkOrder(input string name, input int n, input int first);
        checkOutput({name, "_count"}, grant_log.size(), n);
        for (int i = 0; i < n && i < grant_log.size(); i++)
            checkOutput($sformatf("%s_%0d", name, i), grant_log[i], (first + i) % 2);
    endtask

    // Stop the run if anything deadlocks beyond the bounded waits.
    initial begin
        #300000;
        $display("[TB] FAIL global_timeout: simulation still running at %0t, expected to be done", $time);
        $fatal(1, "[TB] global timeout");
    end

    // Directed test sequence.
    initial begin
        logic [31:0] rd;
        bit err;
        int cyc;

        reset = 1'b1;
        m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
        m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
        slave_en = 1'b1;
        lat = 2;
        for (int i = 0; i < 256; i++) begin slv_mem[i] = '0; ref_mem[i] = '0; end
        slv_mem[32'h10 >> 2] = 32'h00000004; ref_mem[32'h10 >> 2] = 32'h00000004;
        slv_mem[32'h24 >> 2] = 32'h11223344; ref_mem[32'h24 >> 2] = 32'h11223344;
        slv_mem[32'h30 >> 2] = 32'h12345678; ref_mem[32'h30 >> 2] = 32'h12345678;

        // Outputs while in reset.
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_s_valid", {31'b0, s_valid}, 32'h0);
        checkOutput("rst_m0_ready", {31'b0, m0_ready}, 32'h0);
        checkOutput("rst_m1_ready", {31'b0, m1_ready}, 32'h0);
        checkOutput("rst_timeout_err", {31'b0, timeout_err}, 32'h0);
        checkOutput("rst_s_addr", s_addr, 32'h0);
        reset = 1'b0;

        // Single read on port 0, with the shared port checked just after the grant edge.
        fork
            applyStimulus(0, 32'h10, 32'h0, 4'h0, rd, err, cyc);
            begin
                @(posedge clk);
                #1;
                checkOutput("t1_s_addr", s_addr, 32'h10);
                checkOutput("t1_s_wstrb", {28'b0, s_wstrb}, 32'h0);
                checkOutput("t1_s_valid", {31'b0, s_valid}, 32'h1);
            end
        join
        checkOutput("t1_rdata", rd, 32'h00000004);
        checkOutput("t1_err", {31'b0, err}, 32'h0);
        checkOutput("t1_latency", cyc, 3);

        // Write then read on port 1.
        applyStimulus(1, 32'h20, 32'h0000FF00, 4'hF, rd, err, cyc);
        checkOutput("t2_write_err", {31'b0, err}, 32'h0);
        applyStimulus(1, 32'h20, 32'h0, 4'h0, rd, err, cyc);
        checkOutput("t2_read_rdata", rd, 32'h0000FF00);

        // Partial-strobe write: only bytes 0 and 2 change.
        applyStimulus(0, 32'h24, 32'hAABBCCDD, 4'b0101, rd, err, cyc);
        applyStimulus(0, 32'h24, 32'h0, 4'h0, rd, err, cyc);
        checkOutput("strobe_rdata", rd, 32'h11BB33DD);

        // m0 was served last, so a tie now goes to m1 first.
        grant_log.delete();
        tiePair();
        checkOrder("tie_after_m0", 2, 1);

        // After reset, three simultaneous pairs alternate 0,1,0,1,0,1.
        doReset();
        grant_log.delete();
        repeat (3) tiePair();
        checkOrder("rounds", 6, 0);

        // Both masters request back-to-back with valid held continuously, so every IDLE is a tie.
        grant_log.delete();
        fork
            begin
                logic [31:0] ra; bit ea; int ca;
                for (int k = 0; k < 3; k++) applyStimulus(0, 32'h10, 32'h0, 4'h0, ra, ea, ca);
            end
            begin
                logic [31:0] rb; bit eb; int cb;
                for (int k = 0; k < 3; k++) applyStimulus(1, 32'h20, 32'h0, 4'h0, rb, eb, cb);
            end
        join
        checkOrder("b2b", 6, 0);

        // Watchdog: the slave never answers, then m1 is served normally.
        slave_en = 1'b0;
        applyStimulus(0, 32'h10, 32'h0, 4'h0, rd, err, cyc);
        checkOutput("wd_rdata", rd, 32'hDEADBEEF);
        checkOutput("wd_err", {31'b0, err}, 32'h1);
        checkOutput("wd_latency", cyc, TMO + 1);
        slave_en = 1'b1;
        applyStimulus(1, 32'h20, 32'h0, 4'h0, rd, err, cyc);
        checkOutput("wd_next_rdata", rd, 32'h0000FF00);
        checkOutput("wd_next_err", {31'b0, err}, 32'h0);

        // Hold stability: changing m0_addr during BUSY must not reach s_addr.
        lat = 5;
        fork
            applyStimulus(0, 32'h30, 32'h0, 4'h0, rd, err, cyc);
            begin
                repeat (2) @(posedge clk);
                #2;
                m0_addr = 32'h44;
                @(posedge clk);
                #1;
                checkOutput("hold_s_addr", s_addr, 32'h30);
            end
        join
        checkOutput("hold_rdata", rd, 32'h12345678);
        checkOutput("hold_latency", cyc, 6);
        lat = 2;

        // Reset in the middle of BUSY clears outputs immediately.
        slave_en = 1'b0;
        @(posedge clk);
        #1;
        m0_valid = 1'b1; m0_addr = 32'h10; m0_wdata = 32'h0; m0_wstrb = 4'h0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("mid_busy_s_valid", {31'b0, s_valid}, 32'h1);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("mid_rst_s_valid", {31'b0, s_valid}, 32'h0);
        checkOutput("mid_rst_s_addr", s_addr, 32'h0);
        checkOutput("mid_rst_m0_rdata", m0_rdata, 32'h0);
        checkOutput("mid_rst_m1_rdata", m1_rdata, 32'h0);
        checkOutput("mid_rst_ready", {30'b0, m1_ready, m0_ready}, 32'h0);
        m0_valid = 1'b0;
        slave_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        grant_log.delete();
        tiePair();
        checkOrder("post_rst", 2, 0);

        repeat (3) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
